// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage_if
//  Brief    : Fetch-stage bus: backend control, instruction BRAM port, IF/ID.
//  Revision : 1.0
// ============================================================================
interface fetch_stage_if #(
  parameter int IMEM_AW = 14
) ();
  logic               stall;
  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic               imem_en;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic [31:0]        id_inst;
  logic [31:0]        id_pc;
  logic               id_valid;

  modport master (
    input  stall, redirect_valid, redirect_pc, imem_rdata,
    output imem_en, imem_addr, id_inst, id_pc, id_valid
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, imem_rdata,
    input  imem_en, imem_addr, id_inst, id_pc, id_valid
  );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Brief    : rv32i IF stage and IF/ID boundary with stall hold buffer and
//             redirect flush over a 1-cycle-latency instruction BRAM.
//  Revision : 1.0
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 14,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  fetch_stage_if.master       bus
);

  logic [31:0] r_fetch_pc;
  logic [31:0] r_resp_pc;
  logic        r_resp_valid;
  logic [31:0] r_hold_inst;
  logic        r_hold_valid;

  logic [31:0] w_redirect_target;
  logic [31:0] w_id_inst;

  // Low two bits of the redirect target are dropped to keep fetches word aligned.
  assign w_redirect_target = bus.redirect_pc & 32'hFFFF_FFFC;

  always_comb begin
    w_id_inst = NOP_INST;
    if (r_resp_valid) begin
      w_id_inst = r_hold_valid ? r_hold_inst : bus.imem_rdata;
    end
  end

  assign bus.imem_en   = ~bus.stall | bus.redirect_valid;
  assign bus.imem_addr = r_fetch_pc[IMEM_AW+1:2];
  assign bus.id_valid  = r_resp_valid;
  assign bus.id_pc     = r_resp_pc;
  assign bus.id_inst   = w_id_inst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc   <= RESET_PC;
      r_resp_pc    <= RESET_PC;
      r_resp_valid <= 1'b0;
      r_hold_inst  <= NOP_INST;
      r_hold_valid <= 1'b0;
    end else if (bus.redirect_valid) begin
      r_fetch_pc   <= w_redirect_target;
      r_resp_valid <= 1'b0;
      r_hold_valid <= 1'b0;
    end else if (!bus.stall) begin
      r_resp_pc    <= r_fetch_pc;
      r_resp_valid <= 1'b1;
      r_fetch_pc   <= r_fetch_pc + 32'd4;
      r_hold_valid <= 1'b0;
    end else if (!r_hold_valid && r_resp_valid) begin
      // BRAM output is only trustworthy in the first stall cycle; capture it then.
      r_hold_inst  <= bus.imem_rdata;
      r_hold_valid <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Brief    : Self-checking bench for fetch_stage with a BRAM model.
//  Revision : 1.0
// ============================================================================
module tb_fetch_stage;

  localparam int AW = 14;

  typedef struct {
    logic          stall;
    logic          redir;
    logic [31:0]   rpc;
    logic          e_valid;
    logic [31:0]   e_pc;
    logic [31:0]   e_inst;
    logic          e_en;
    logic [AW-1:0] e_addr;
  } vec_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  vec_t exp_q[$];
  vec_t tbl_main[$];
  vec_t tbl_redir[$];

  fetch_stage_if #(.IMEM_AW(AW)) bus ();

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .IMEM_AW  (AW),
    .NOP_INST (32'h0000_0013)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: mem[i] = 0x1000_0000 + i; garbage after a disabled cycle.
  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_rdata <= 32'h1000_0000 + 32'(bus.imem_addr);
    else             bus.imem_rdata <= 32'hDEAD_BEEF;
  end

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rpc,
                              input logic v, input logic [31:0] pc, input logic [31:0] inst,
                              input logic en, input logic [AW-1:0] addr);
    vec_t t;
    t.stall = s; t.redir = r; t.rpc = rpc;
    t.e_valid = v; t.e_pc = pc; t.e_inst = inst; t.e_en = en; t.e_addr = addr;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Pop the oldest expectation and compare it against the live outputs.
  task automatic drain(input string tag);
    vec_t e;
    if (exp_q.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".id_valid"},  32'(bus.id_valid),  32'(e.e_valid));
      check({tag, ".id_pc"},     bus.id_pc,          e.e_pc);
      check({tag, ".id_inst"},   bus.id_inst,        e.e_inst);
      check({tag, ".imem_en"},   32'(bus.imem_en),   32'(e.e_en));
      check({tag, ".imem_addr"}, 32'(bus.imem_addr), 32'(e.e_addr));
    end
  endtask

  // Called just after a rising edge: drive, score at the falling edge, advance.
  task automatic run_vec(input vec_t v, input string tag);
    bus.stall          = v.stall;
    bus.redirect_valid = v.redir;
    bus.redirect_pc    = v.rpc;
    exp_q.push_back(v);
    @(negedge clk);
    drain(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;

    // reset / stream / stall / redirect / redirect+stall / wrap
    for (int i = 0; i < 3; i++)
      tbl_main.push_back(mk(0,0,0,      0,32'h0,        32'h13,        1,14'h0));
    tbl_main.push_back(mk(0,0,0,        0,32'h0,        32'h13,        1,14'h0));     // release cycle
    tbl_main.push_back(mk(0,0,0,        1,32'h0,        32'h1000_0000, 1,14'h1));
    tbl_main.push_back(mk(0,0,0,        1,32'h4,        32'h1000_0001, 1,14'h2));
    tbl_main.push_back(mk(1,0,0,        1,32'h8,        32'h1000_0002, 0,14'h3));
    tbl_main.push_back(mk(1,0,0,        1,32'h8,        32'h1000_0002, 0,14'h3));
    tbl_main.push_back(mk(1,0,0,        1,32'h8,        32'h1000_0002, 0,14'h3));
    tbl_main.push_back(mk(0,0,0,        1,32'h8,        32'h1000_0002, 1,14'h3));
    tbl_main.push_back(mk(0,0,0,        1,32'hC,        32'h1000_0003, 1,14'h4));
    tbl_main.push_back(mk(0,1,32'h40,   1,32'h10,       32'h1000_0004, 1,14'h5));
    tbl_main.push_back(mk(0,0,0,        0,32'h10,       32'h13,        1,14'h10));
    tbl_main.push_back(mk(0,0,0,        1,32'h40,       32'h1000_0010, 1,14'h11));
    tbl_main.push_back(mk(1,0,0,        1,32'h44,       32'h1000_0011, 0,14'h12));
    tbl_main.push_back(mk(1,1,32'h82,   1,32'h44,       32'h1000_0011, 1,14'h12));
    tbl_main.push_back(mk(0,0,0,        0,32'h44,       32'h13,        1,14'h20));
    tbl_main.push_back(mk(0,1,32'hFFFF_FFFC, 1,32'h80,  32'h1000_0020, 1,14'h21));
    tbl_main.push_back(mk(0,0,0,        0,32'h80,       32'h13,        1,14'h3FFF));
    tbl_main.push_back(mk(0,0,0,        1,32'hFFFF_FFFC,32'h1000_3FFF, 1,14'h0));
    tbl_main.push_back(mk(0,0,0,        1,32'h0,        32'h1000_0000, 1,14'h1));

    // after async reset: redirect to 0x40 while id_pc=4
    tbl_redir.push_back(mk(0,0,0,       0,32'h0,        32'h13,        1,14'h0));
    tbl_redir.push_back(mk(0,0,0,       1,32'h0,        32'h1000_0000, 1,14'h1));
    tbl_redir.push_back(mk(0,1,32'h40,  1,32'h4,        32'h1000_0001, 1,14'h2));
    tbl_redir.push_back(mk(0,0,0,       0,32'h4,        32'h13,        1,14'h10));
    tbl_redir.push_back(mk(0,0,0,       1,32'h40,       32'h1000_0010, 1,14'h11));
    tbl_redir.push_back(mk(0,0,0,       1,32'h44,       32'h1000_0011, 1,14'h12));

    @(posedge clk);
    #1;
    for (int i = 0; i < tbl_main.size(); i++) begin
      if (i == 3) rst_n = 1'b1;
      run_vec(tbl_main[i], $sformatf("main[%0d]", i));
    end

    // Asynchronous reset between edges, mid-stream.
    bus.stall = 1'b0; bus.redirect_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.push_back(mk(0,0,0, 0,32'h0, 32'h13, 1,14'h0));
    #1;
    drain("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < tbl_redir.size(); i++)
      run_vec(tbl_redir[i], $sformatf("redir[%0d]", i));

    check("scoreboard_leftover", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
